// File: rtl/d_cache_wb.sv
// Direct-mapped, write-back, write-allocate data cache: one line per DATA_W word,
// byte-strobed stores, valid/ready memory port, flush walk, saturating hit/miss counters.
module d_cache_wb #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int INDEX_W = 8,
    parameter int CNT_W   = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    output logic                resp_valid,
    output logic [DATA_W-1:0]   resp_rdata,
    output logic                resp_hit,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_req_write,
    output logic [ADDR_W-1:0]   mem_req_addr,
    output logic [DATA_W-1:0]   mem_req_wdata,
    input  logic                mem_resp_valid,
    input  logic [DATA_W-1:0]   mem_resp_rdata,
    input  logic                flush_start,
    output logic                flush_done,
    output logic                busy,
    output logic [CNT_W-1:0]    hit_count,
    output logic [CNT_W-1:0]    miss_count
);
    localparam int BYTES = DATA_W / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int TAG_W = ADDR_W - OFF - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB, S_REFILL_REQ, S_REFILL_WAIT, S_RESP, S_FLUSH_SCAN, S_FLUSH_WB
    } state_t;

    state_t             r_state;
    logic               r_write;
    logic [INDEX_W-1:0] r_idx;
    logic [TAG_W-1:0]   r_tag;
    logic [DATA_W-1:0]  r_wdata;
    logic [BYTES-1:0]   r_wstrb;
    logic [LINES-1:0]   r_valid;
    logic [LINES-1:0]   r_dirty;
    logic [INDEX_W-1:0] r_flush_idx;
    logic               r_flush_done;
    logic [DATA_W-1:0]  r_line;
    logic [CNT_W-1:0]   r_hit_count;
    logic [CNT_W-1:0]   r_miss_count;

    logic [DATA_W-1:0]  r_data_mem [LINES];
    logic [TAG_W-1:0]   r_tag_mem  [LINES];
    logic [DATA_W-1:0]  r_rd_data;
    logic [TAG_W-1:0]   r_rd_tag;

    logic [INDEX_W-1:0] w_req_idx;
    logic [TAG_W-1:0]   w_req_tag;
    logic [INDEX_W-1:0] w_rd_idx;
    logic               w_hit;
    logic               w_lookup_hit;
    logic               w_victim_dirty;
    logic               w_flush_dirty;
    logic               w_flush_last;
    logic [DATA_W-1:0]  w_lookup_merge;
    logic [DATA_W-1:0]  w_refill_merge;
    logic               w_mem_we;
    logic [DATA_W-1:0]  w_mem_wdata;
    logic [ADDR_W-1:0]  w_mem_addr;
    logic               w_unused;

    function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] t,
                                                    input logic [INDEX_W-1:0] i);
        return ADDR_W'({t, i}) << OFF;
    endfunction

    assign w_req_idx      = req_addr[OFF+INDEX_W-1:OFF];
    assign w_req_tag      = req_addr[ADDR_W-1:OFF+INDEX_W];
    assign w_unused       = &{1'b0, req_addr[OFF-1:0]};
    assign w_hit          = r_valid[r_idx] && (r_rd_tag == r_tag);
    assign w_lookup_hit   = (r_state == S_LOOKUP) && w_hit;
    assign w_victim_dirty = r_valid[r_idx] && r_dirty[r_idx];
    assign w_flush_dirty  = r_valid[r_flush_idx] && r_dirty[r_flush_idx];
    assign w_flush_last   = (r_flush_idx == {INDEX_W{1'b1}});

    // r_wstrb is zero for loads, so the merges pass the old/refill line through unchanged
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_merge
        assign w_lookup_merge[gi*8 +: 8] = r_wstrb[gi] ? r_wdata[gi*8 +: 8] : r_rd_data[gi*8 +: 8];
        assign w_refill_merge[gi*8 +: 8] = r_wstrb[gi] ? r_wdata[gi*8 +: 8] : mem_resp_rdata[gi*8 +: 8];
    end

    always_comb begin
        w_rd_idx = r_idx;
        if (r_state == S_IDLE)
            w_rd_idx = w_req_idx;
        else if (r_state == S_FLUSH_SCAN || r_state == S_FLUSH_WB)
            w_rd_idx = r_flush_idx;
    end

    assign w_mem_we    = !reset && ((w_lookup_hit && r_write) ||
                                    (r_state == S_REFILL_WAIT && mem_resp_valid));
    assign w_mem_wdata = (r_state == S_LOOKUP) ? w_lookup_merge : w_refill_merge;

    // Line storage: registered read, read address follows the state so data is ready next cycle
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_data_mem[r_idx] <= w_mem_wdata;
            r_tag_mem[r_idx]  <= r_tag;
        end
        r_rd_data <= r_data_mem[w_rd_idx];
        r_rd_tag  <= r_tag_mem[w_rd_idx];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_dirty      <= '0;
            r_hit_count  <= '0;
            r_miss_count <= '0;
            r_flush_done <= 1'b0;
            r_flush_idx  <= '0;
        end else begin
            r_flush_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (flush_start) begin
                        r_flush_idx <= '0;
                        r_state     <= S_FLUSH_SCAN;
                    end else if (req_valid) begin
                        r_write <= req_write;
                        r_idx   <= w_req_idx;
                        r_tag   <= w_req_tag;
                        r_wdata <= req_wdata;
                        r_wstrb <= req_write ? req_wstrb : '0;
                        r_state <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (w_hit) begin
                        if (r_hit_count != {CNT_W{1'b1}})
                            r_hit_count <= r_hit_count + CNT_W'(1);
                        if (r_write)
                            r_dirty[r_idx] <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_miss_count != {CNT_W{1'b1}})
                            r_miss_count <= r_miss_count + CNT_W'(1);
                        r_state <= w_victim_dirty ? S_WB : S_REFILL_REQ;
                    end
                end
                S_WB: if (mem_req_ready) r_state <= S_REFILL_REQ;
                S_REFILL_REQ: if (mem_req_ready) r_state <= S_REFILL_WAIT;
                S_REFILL_WAIT: begin
                    if (mem_resp_valid) begin
                        r_valid[r_idx] <= 1'b1;
                        r_dirty[r_idx] <= r_write;
                        r_line         <= w_refill_merge;
                        r_state        <= S_RESP;
                    end
                end
                S_RESP: r_state <= S_IDLE;
                S_FLUSH_SCAN: begin
                    if (w_flush_dirty) begin
                        r_state <= S_FLUSH_WB;
                    end else if (w_flush_last) begin
                        r_flush_done <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        r_flush_idx <= r_flush_idx + INDEX_W'(1);
                    end
                end
                S_FLUSH_WB: begin
                    if (mem_req_ready) begin
                        r_dirty[r_flush_idx] <= 1'b0;
                        if (w_flush_last) begin
                            r_flush_done <= 1'b1;
                            r_state      <= S_IDLE;
                        end else begin
                            r_flush_idx <= r_flush_idx + INDEX_W'(1);
                            r_state     <= S_FLUSH_SCAN;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_mem_addr = '0;
        case (r_state)
            S_WB:         w_mem_addr = line_addr(r_rd_tag, r_idx);
            S_FLUSH_WB:   w_mem_addr = line_addr(r_rd_tag, r_flush_idx);
            S_REFILL_REQ: w_mem_addr = line_addr(r_tag, r_idx);
            default:      w_mem_addr = '0;
        endcase
    end

    // Every output is forced low while reset is asserted
    assign req_ready     = !reset && (r_state == S_IDLE) && !flush_start;
    assign resp_valid    = !reset && (w_lookup_hit || r_state == S_RESP);
    assign resp_hit      = !reset && w_lookup_hit;
    assign resp_rdata    = reset ? '0 : (r_state == S_RESP) ? r_line :
                           w_lookup_hit ? w_lookup_merge : '0;
    assign mem_req_valid = !reset && (r_state == S_WB || r_state == S_REFILL_REQ ||
                                      r_state == S_FLUSH_WB);
    assign mem_req_write = !reset && (r_state == S_WB || r_state == S_FLUSH_WB);
    assign mem_req_addr  = reset ? '0 : w_mem_addr;
    assign mem_req_wdata = (!reset && (r_state == S_WB || r_state == S_FLUSH_WB)) ? r_rd_data : '0;
    assign flush_done    = !reset && r_flush_done;
    assign busy          = !reset && (r_state != S_IDLE);
    assign hit_count     = reset ? '0 : r_hit_count;
    assign miss_count    = reset ? '0 : r_miss_count;

endmodule

// File: tb/tb_d_cache_wb.sv
// Directed bench for d_cache_wb: bench-side memory responder, per-scenario tasks with inline checks.
module tb_d_cache_wb;
    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [7:0]  req_wstrb;
    logic        resp_valid, resp_hit;
    logic [63:0] resp_rdata;
    logic        mem_req_valid, mem_req_ready, mem_req_write;
    logic [63:0] mem_req_addr, mem_req_wdata;
    logic        mem_resp_valid;
    logic [63:0] mem_resp_rdata;
    logic        flush_start, flush_done, busy;
    logic [2:0]  hit_count, miss_count;

    int errors = 0;
    int checks = 0;

    logic        log_wr[$];
    logic [63:0] log_addr[$];
    logic [63:0] log_data[$];
    int          stall_cycles;
    bit          stall_unstable;
    bit          resp_in_stall;
    logic [63:0] got_rdata;
    logic        got_hit;
    int          got_lat;

    d_cache_wb #(.ADDR_W(64), .DATA_W(64), .INDEX_W(8), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_hit(resp_hit),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_resp_valid(mem_resp_valid),
        .mem_resp_rdata(mem_resp_rdata), .flush_start(flush_start),
        .flush_done(flush_done), .busy(busy),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic clear_log();
        log_wr.delete();
        log_addr.delete();
        log_data.delete();
    endtask

    // One LSU transaction; the bench answers memory requests, stalling the first 'hold' of them
    task automatic do_req(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] wstrb, input logic [63:0] refill, input int hold);
        bit accepted = 0, pend = 0, done = 0, stalled = 0;
        int acc_k = 0, cnt = 0;
        logic [63:0] s_addr = '0, s_data = '0;
        clear_log();
        stall_cycles = 0; stall_unstable = 0; resp_in_stall = 0;
        got_rdata = '0; got_hit = 1'bx; got_lat = -1;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            req_valid = !accepted; req_write = wr; req_addr = addr;
            req_wdata = wdata; req_wstrb = wstrb;
            mem_resp_valid = pend; mem_resp_rdata = pend ? refill : 64'h0; pend = 0;
            mem_req_ready = (cnt >= hold);
            #1;
            if (mem_req_valid) begin
                if (mem_req_ready) begin
                    if (stalled && (mem_req_addr !== s_addr || mem_req_wdata !== s_data))
                        stall_unstable = 1;
                    stalled = 0;
                    log_wr.push_back(mem_req_write);
                    log_addr.push_back(mem_req_addr);
                    log_data.push_back(mem_req_wdata);
                    if (!mem_req_write) pend = 1;
                end else begin
                    if (!stalled) begin
                        stalled = 1; s_addr = mem_req_addr; s_data = mem_req_wdata;
                    end else if (mem_req_addr !== s_addr || mem_req_wdata !== s_data) begin
                        stall_unstable = 1;
                    end
                    if (resp_valid) resp_in_stall = 1;
                    cnt++; stall_cycles++;
                end
            end
            if (req_valid && req_ready) begin accepted = 1; acc_k = k; end
            if (resp_valid) begin
                got_rdata = resp_rdata; got_hit = resp_hit; got_lat = k - acc_k; done = 1;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL req_timeout: addr=%h no response, required one within 200 cycles", addr);
        end
        $display("txn wr=%0d addr=%h rdata=%h hit=%0d lat=%0d memops=%0d",
                 wr, addr, got_rdata, got_hit, got_lat, log_addr.size());
        @(negedge clk);
        req_valid = 0; mem_resp_valid = 0; mem_req_ready = 0;
    endtask

    task automatic test_reset();
        reset = 1; req_valid = 0; req_write = 0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0; flush_start = 0;
        repeat (3) @(negedge clk);
        req_valid = 1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b required 0", req_ready); end
        checks++; if (busy !== 1'b0 || mem_req_valid !== 1'b0 || resp_valid !== 1'b0) begin
            errors++; $display("FAIL reset_outputs: busy=%b mem_req_valid=%b resp_valid=%b required 0", busy, mem_req_valid, resp_valid); end
        @(negedge clk);
        reset = 0; req_valid = 0; #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b required 1", req_ready); end
        checks++; if (hit_count !== 3'd0 || miss_count !== 3'd0) begin
            errors++; $display("FAIL reset_counts: hit=%0d miss=%0d required 0/0", hit_count, miss_count); end
        $display("txn reset released");
    endtask

    task automatic test_load_miss_hit();
        do_req(0, 64'h100, '0, '0, 64'hAAAA, 0);
        checks++; if (log_addr.size() != 1) begin errors++; $display("FAIL miss_memops: got %0d required 1", log_addr.size()); end
        else begin
            checks++; if (log_wr[0] !== 1'b0 || log_addr[0] !== 64'h100) begin
                errors++; $display("FAIL miss_refill_addr: got wr=%b addr=%h required wr=0 addr=100", log_wr[0], log_addr[0]); end
        end
        checks++; if (got_hit !== 1'b0 || got_rdata !== 64'hAAAA) begin
            errors++; $display("FAIL miss_resp: got hit=%b rdata=%h required hit=0 rdata=aaaa", got_hit, got_rdata); end
        checks++; if (miss_count !== 3'd1) begin errors++; $display("FAIL miss_count1: got %0d required 1", miss_count); end
        do_req(0, 64'h100, '0, '0, 64'h0, 0);
        checks++; if (got_hit !== 1'b1 || got_lat != 1 || got_rdata !== 64'hAAAA) begin
            errors++; $display("FAIL load_hit: got hit=%b lat=%0d rdata=%h required hit=1 lat=1 rdata=aaaa", got_hit, got_lat, got_rdata); end
        checks++; if (hit_count !== 3'd1 || log_addr.size() != 0) begin
            errors++; $display("FAIL hit_count1: got hits=%0d memops=%0d required 1/0", hit_count, log_addr.size()); end
    endtask

    task automatic test_store_merge();
        do_req(1, 64'h100, 64'h11, 8'h01, 64'h0, 0);
        checks++; if (got_hit !== 1'b1 || got_rdata !== 64'hAA11) begin
            errors++; $display("FAIL store_hit: got hit=%b rdata=%h required hit=1 rdata=aa11", got_hit, got_rdata); end
        do_req(0, 64'h104, '0, '0, 64'h0, 0);
        checks++; if (got_hit !== 1'b1 || got_rdata !== 64'hAA11) begin
            errors++; $display("FAIL load_after_store: got hit=%b rdata=%h required hit=1 rdata=aa11", got_hit, got_rdata); end
        checks++; if (hit_count !== 3'd3) begin errors++; $display("FAIL hit_count3: got %0d required 3", hit_count); end
    endtask

    task automatic test_evict_stall();
        do_req(0, 64'h900, '0, '0, 64'h5555, 5);
        checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL evict_memops: got %0d required 2", log_addr.size()); end
        else begin
            checks++; if (log_wr[0] !== 1'b1 || log_addr[0] !== 64'h100 || log_data[0] !== 64'hAA11) begin
                errors++; $display("FAIL evict_wb: got wr=%b addr=%h data=%h required wr=1 addr=100 data=aa11", log_wr[0], log_addr[0], log_data[0]); end
            checks++; if (log_wr[1] !== 1'b0 || log_addr[1] !== 64'h900) begin
                errors++; $display("FAIL evict_refill: got wr=%b addr=%h required wr=0 addr=900", log_wr[1], log_addr[1]); end
        end
        checks++; if (stall_cycles != 5 || stall_unstable || resp_in_stall) begin
            errors++; $display("FAIL wb_stall: got cycles=%0d unstable=%0d resp=%0d required 5/0/0", stall_cycles, stall_unstable, resp_in_stall); end
        checks++; if (got_hit !== 1'b0 || got_rdata !== 64'h5555 || miss_count !== 3'd2) begin
            errors++; $display("FAIL evict_resp: got hit=%b rdata=%h miss=%0d required 0/5555/2", got_hit, got_rdata, miss_count); end
    endtask

    task automatic test_flush();
        int pulses = 0, tail = -1;
        bit resp_seen = 0;
        do_req(1, 64'h18, 64'hFF, 8'h01, 64'h1234_0000, 0);
        checks++; if (got_hit !== 1'b0 || got_rdata !== 64'h1234_00FF || log_addr.size() != 1) begin
            errors++; $display("FAIL store_miss3: got hit=%b rdata=%h memops=%0d required 0/123400ff/1", got_hit, got_rdata, log_addr.size()); end
        do_req(1, 64'h640, 64'hDEAD_BEEF, 8'h0F, 64'h5A5A_5A5A_0000_0000, 0);
        checks++; if (got_rdata !== 64'h5A5A_5A5A_DEAD_BEEF) begin
            errors++; $display("FAIL store_miss200: got %h required 5a5a5a5adeadbeef", got_rdata); end
        clear_log();
        @(negedge clk);
        flush_start = 1; req_valid = 1; req_write = 0; req_addr = 64'h18; mem_req_ready = 1; #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_priority: req_ready=%b required 0", req_ready); end
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            flush_start = 0; req_valid = 0; #1;
            if (mem_req_valid && mem_req_ready) begin
                log_wr.push_back(mem_req_write); log_addr.push_back(mem_req_addr); log_data.push_back(mem_req_wdata);
            end
            if (resp_valid) resp_seen = 1;
            if (flush_done) begin pulses++; if (tail < 0) tail = 3; end
            else if (tail > 0) tail--;
            if (tail == 0) break;
        end
        mem_req_ready = 0;
        $display("txn flush writes=%0d done_pulses=%0d", log_addr.size(), pulses);
        checks++; if (pulses != 1 || resp_seen) begin
            errors++; $display("FAIL flush_done: got pulses=%0d resp=%0d required 1/0", pulses, resp_seen); end
        checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL flush_writes: got %0d required 2", log_addr.size()); end
        else begin
            checks++; if (log_wr[0] !== 1'b1 || log_addr[0] !== 64'h18 || log_data[0] !== 64'h1234_00FF) begin
                errors++; $display("FAIL flush_wb3: got wr=%b addr=%h data=%h required 1/18/123400ff", log_wr[0], log_addr[0], log_data[0]); end
            checks++; if (log_wr[1] !== 1'b1 || log_addr[1] !== 64'h640 || log_data[1] !== 64'h5A5A_5A5A_DEAD_BEEF) begin
                errors++; $display("FAIL flush_wb200: got wr=%b addr=%h data=%h required 1/640/5a5a5a5adeadbeef", log_wr[1], log_addr[1], log_data[1]); end
        end
        do_req(0, 64'h818, '0, '0, 64'h818, 0);
        checks++; if (log_addr.size() != 1 || log_wr[0] !== 1'b0 || log_addr[0] !== 64'h818) begin
            errors++; $display("FAIL post_flush_evict3: got memops=%0d first_addr=%h required 1 read at 818", log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 64'h0); end
        do_req(0, 64'hE40, '0, '0, 64'hE40E40, 0);
        checks++; if (log_addr.size() != 1 || log_wr[0] !== 1'b0 || log_addr[0] !== 64'hE40) begin
            errors++; $display("FAIL post_flush_evict200: got memops=%0d first_addr=%h required 1 read at e40", log_addr.size(), log_addr.size() > 0 ? log_addr[0] : 64'h0); end
        checks++; if (miss_count !== 3'd6) begin errors++; $display("FAIL miss_count6: got %0d required 6", miss_count); end
    endtask

    task automatic test_clean_flush();
        int busy_cycles = 0, memops = 0;
        bit done = 0;
        @(negedge clk);
        flush_start = 1; mem_req_ready = 1; #1;
        for (int k = 0; k < 600 && !done; k++) begin
            @(negedge clk);
            flush_start = 0; #1;
            if (busy) busy_cycles++;
            if (mem_req_valid) memops++;
            if (flush_done) done = 1;
        end
        mem_req_ready = 0;
        $display("txn clean_flush busy_cycles=%0d memops=%0d", busy_cycles, memops);
        checks++; if (!done || busy_cycles != 256 || memops != 0) begin
            errors++; $display("FAIL clean_flush: got done=%0d cycles=%0d memops=%0d required 1/256/0", done, busy_cycles, memops); end
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 4; i++) do_req(0, 64'hE40, '0, '0, 64'h0, 0);
        checks++; if (hit_count !== 3'd7 || got_rdata !== 64'hE40E40) begin
            errors++; $display("FAIL hit_count7: got hits=%0d rdata=%h required 7/e40e40", hit_count, got_rdata); end
        do_req(0, 64'hE40, '0, '0, 64'h0, 0);
        checks++; if (hit_count !== 3'd7) begin errors++; $display("FAIL hit_saturate: got %0d required 7", hit_count); end
        do_req(0, 64'h1640, '0, '0, 64'h1640, 0);
        checks++; if (miss_count !== 3'd7) begin errors++; $display("FAIL miss_count7: got %0d required 7", miss_count); end
        do_req(0, 64'h2640, '0, '0, 64'h2640, 0);
        checks++; if (miss_count !== 3'd7 || got_hit !== 1'b0) begin
            errors++; $display("FAIL miss_saturate: got miss=%0d hit=%b required 7/0", miss_count, got_hit); end
    endtask

    task automatic test_reset_mid();
        bit saw_read = 0, bad = 0;
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 64'h3000; mem_req_ready = 1; #1;
        for (int k = 0; k < 50 && !saw_read; k++) begin
            @(negedge clk);
            req_valid = 0; #1;
            if (mem_req_valid && mem_req_ready && !mem_req_write) saw_read = 1;
        end
        checks++; if (!saw_read) begin errors++; $display("FAIL mid_refill_req: no refill read seen, required one"); end
        @(negedge clk);
        reset = 1; #1;
        if (resp_valid || mem_req_valid) bad = 1;
        @(negedge clk);
        reset = 0; mem_resp_valid = 1; mem_resp_rdata = 64'h777; #1;
        if (resp_valid || mem_req_valid) bad = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            mem_resp_valid = 0; #1;
            if (resp_valid || mem_req_valid || busy) bad = 1;
        end
        mem_req_ready = 0;
        $display("txn reset during refill wait");
        checks++; if (bad) begin errors++; $display("FAIL mid_reset_quiet: response or memory activity after reset, required none"); end
        checks++; if (hit_count !== 3'd0 || miss_count !== 3'd0) begin
            errors++; $display("FAIL mid_reset_counts: got hit=%0d miss=%0d required 0/0", hit_count, miss_count); end
        do_req(0, 64'h3000, '0, '0, 64'h3333, 0);
        checks++; if (got_hit !== 1'b0 || got_rdata !== 64'h3333 || log_addr.size() != 1) begin
            errors++; $display("FAIL mid_reset_reload: got hit=%b rdata=%h memops=%0d required 0/3333/1", got_hit, got_rdata, log_addr.size()); end
        do_req(0, 64'h2640, '0, '0, 64'h4444, 0);
        checks++; if (got_hit !== 1'b0 || miss_count !== 3'd2) begin
            errors++; $display("FAIL mid_reset_invalid: got hit=%b miss=%0d required 0/2", got_hit, miss_count); end
    endtask

    initial begin
        test_reset();
        test_load_miss_hit();
        test_store_merge();
        test_evict_stall();
        test_flush();
        test_clean_flush();
        test_saturation();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
